// File: rtl/dbi_phy_pkg.sv
// Shared types and constants for the DBI type-B PHY (FSM state encoding, timer load helpers).
package dbi_phy_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_HRST     = 4'd1,
    ST_CMD_L    = 4'd2,
    ST_CMD_H    = 4'd3,
    ST_DAT_L    = 4'd4,
    ST_DAT_H    = 4'd5,
    ST_DAT_WAIT = 4'd6,
    ST_PAUSE    = 4'd7,
    ST_RD_L     = 4'd8,
    ST_RD_H     = 4'd9
  } dbi_state_e;

  // Shortest phase is one cycle; the timer is loaded with (cycles - 1) and tested at zero.
  localparam int unsigned TMR_MIN_CYC = 1;
  localparam int unsigned TMR_LD_ADJ  = 1;

endpackage

// File: rtl/dbi_phy_tmr.sv
// Loadable down-counter with a registered done flag; saturates at zero instead of wrapping.
module dbi_phy_tmr #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == '0);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/dbi_phy_gen2.sv
// MIPI DBI type-B (8080-style) write PHY with hardware-reset beats.
// Define DBI_PHY_RD_EN to compile in read transactions (RDX strobe and rx data port).
module dbi_phy_gen2
  import dbi_phy_pkg::*;
#(
  parameter int unsigned DBI_IF_D_W = 8,
  parameter int unsigned TMR_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TMR_W-1:0]      cfg_t_wrl_i,
  input  logic [TMR_W-1:0]      cfg_t_wrh_i,
  input  logic [TMR_W-1:0]      cfg_t_hrst_i,
  input  logic [TMR_W-1:0]      cfg_t_pau_i,
  input  logic                  dtf_dbi_hrst_i,
  input  logic [DBI_IF_D_W-1:0] dtf_tx_cmd_typ_i,
  input  logic [DBI_IF_D_W-1:0] dtf_tx_cmd_dat_i,
  input  logic                  dtf_tx_no_dat_i,
  input  logic                  dtf_tx_last_i,
  input  logic                  dtf_tx_vld_i,
  output logic                  dtf_tx_rdy_o,
  output logic                  busy_o,
  inout  wire  [DBI_IF_D_W-1:0] dbi_d_io,
  output logic                  dbi_csx_o,
  output logic                  dbi_dcx_o,
  output logic                  dbi_resx_o,
  output logic                  dbi_rdx_o,
  output logic                  dbi_wrx_o
`ifdef DBI_PHY_RD_EN
  ,
  input  logic                  dtf_rd_i,
  input  logic [TMR_W-1:0]      cfg_t_rdl_i,
  input  logic [TMR_W-1:0]      cfg_t_rdh_i,
  output logic [DBI_IF_D_W-1:0] dtf_rx_dat_o,
  output logic                  dtf_rx_vld_o
`endif
);

  function automatic logic [TMR_W-1:0] tmr_ld_val(input logic [TMR_W-1:0] cyc);
    return (cyc < TMR_W'(TMR_MIN_CYC)) ? '0 : cyc - TMR_W'(TMR_LD_ADJ);
  endfunction

  dbi_state_e state_q, state_d;

  logic [DBI_IF_D_W-1:0] cmd_q, cmd_d, dat_q, dat_d, d_q, d_d;
  logic                  no_dat_q, no_dat_d, last_q, last_d, rd_q, rd_d;
  logic [TMR_W-1:0]      wrl_q, wrl_d, wrh_q, wrh_d, hrst_q, hrst_d;
  logic [TMR_W-1:0]      pau_q, pau_d, rdl_q, rdl_d, rdh_q, rdh_d;

  logic csx_q, csx_d, dcx_q, dcx_d, resx_q, resx_d, wrx_q, wrx_d;
  logic oe_q, oe_d, busy_q, busy_d;

  logic             accept_c;
  logic             tmr_ld_c;
  logic [TMR_W-1:0] tmr_val_c;
  logic             tmr_done;

  logic             rd_req_c;
  logic [TMR_W-1:0] cfg_rdl_c, cfg_rdh_c;

`ifdef DBI_PHY_RD_EN
  logic                  rdx_q, rdx_d, rx_vld_q, rx_vld_d;
  logic [DBI_IF_D_W-1:0] rx_dat_q, rx_dat_d;
  assign rd_req_c  = dtf_rd_i;
  assign cfg_rdl_c = cfg_t_rdl_i;
  assign cfg_rdh_c = cfg_t_rdh_i;
`else
  assign rd_req_c  = 1'b0;
  assign cfg_rdl_c = '0;
  assign cfg_rdh_c = '0;
`endif

  assign dtf_tx_rdy_o = (state_q == ST_IDLE) || (state_q == ST_DAT_WAIT);
  assign accept_c     = dtf_tx_vld_i && dtf_tx_rdy_o;

  dbi_phy_tmr #(.W(TMR_W)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (tmr_ld_c),
    .ld_val_i (tmr_val_c),
    .done_o   (tmr_done)
  );

  // Next state, transaction latches, timer load and next output values.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    dat_d    = dat_q;
    no_dat_d = no_dat_q;
    last_d   = last_q;
    rd_d     = rd_q;
    wrl_d    = wrl_q;
    wrh_d    = wrh_q;
    hrst_d   = hrst_q;
    pau_d    = pau_q;
    rdl_d    = rdl_q;
    rdh_d    = rdh_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          wrl_d  = cfg_t_wrl_i;
          wrh_d  = cfg_t_wrh_i;
          hrst_d = cfg_t_hrst_i;
          pau_d  = cfg_t_pau_i;
          rdl_d  = cfg_rdl_c;
          rdh_d  = cfg_rdh_c;
          if (dtf_dbi_hrst_i) begin
            state_d = ST_HRST;
          end else begin
            state_d  = ST_CMD_L;
            cmd_d    = dtf_tx_cmd_typ_i;
            dat_d    = dtf_tx_cmd_dat_i;
            no_dat_d = dtf_tx_no_dat_i;
            last_d   = dtf_tx_last_i;
            rd_d     = rd_req_c;
          end
        end
      end
      ST_HRST:  if (tmr_done) state_d = ST_PAUSE;
      ST_CMD_L: if (tmr_done) state_d = ST_CMD_H;
      ST_CMD_H: begin
        if (tmr_done) begin
          if (no_dat_q)  state_d = ST_PAUSE;
          else if (rd_q) state_d = ST_RD_L;
          else           state_d = ST_DAT_L;
        end
      end
      ST_DAT_L: if (tmr_done) state_d = ST_DAT_H;
      ST_DAT_H: if (tmr_done) state_d = last_q ? ST_PAUSE : ST_DAT_WAIT;
      ST_RD_L:  if (tmr_done) state_d = ST_RD_H;
      ST_RD_H:  if (tmr_done) state_d = last_q ? ST_PAUSE : ST_DAT_WAIT;
      ST_DAT_WAIT: begin
        // The hrst flag has no meaning on a continuation beat.
        if (accept_c) begin
          dat_d   = dtf_tx_cmd_dat_i;
          last_d  = dtf_tx_last_i;
          state_d = rd_q ? ST_RD_L : ST_DAT_L;
        end
      end
      ST_PAUSE: if (tmr_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    tmr_ld_c  = (state_d != state_q);
    tmr_val_c = '0;
    case (state_d)
      ST_HRST:              tmr_val_c = tmr_ld_val(hrst_d);
      ST_CMD_L, ST_DAT_L:   tmr_val_c = tmr_ld_val(wrl_d);
      ST_CMD_H, ST_DAT_H:   tmr_val_c = tmr_ld_val(wrh_d);
      ST_RD_L:              tmr_val_c = tmr_ld_val(rdl_d);
      ST_RD_H:              tmr_val_c = tmr_ld_val(rdh_d);
      ST_PAUSE:             tmr_val_c = tmr_ld_val(pau_d);
      default:              tmr_val_c = '0;
    endcase

    csx_d  = 1'b1;
    dcx_d  = 1'b1;
    resx_d = 1'b1;
    wrx_d  = 1'b1;
    oe_d   = 1'b0;
    d_d    = d_q;
    busy_d = (state_d != ST_IDLE);
`ifdef DBI_PHY_RD_EN
    rdx_d    = 1'b1;
    rx_vld_d = (state_q == ST_RD_L) && tmr_done;
    rx_dat_d = rx_vld_d ? dbi_d_io : rx_dat_q;
`endif
    // Outputs follow the next state so they line up with the registered state.
    case (state_d)
      ST_HRST: resx_d = 1'b0;
      ST_CMD_L: begin
        csx_d = 1'b0; dcx_d = 1'b0; wrx_d = 1'b0; oe_d = 1'b1; d_d = cmd_d;
      end
      ST_CMD_H: begin
        csx_d = 1'b0; dcx_d = 1'b0; oe_d = 1'b1; d_d = cmd_d;
      end
      ST_DAT_L: begin
        csx_d = 1'b0; wrx_d = 1'b0; oe_d = 1'b1; d_d = dat_d;
      end
      ST_DAT_H: begin
        csx_d = 1'b0; oe_d = 1'b1; d_d = dat_d;
      end
      ST_DAT_WAIT: begin
        csx_d = 1'b0; oe_d = !rd_d;
      end
`ifdef DBI_PHY_RD_EN
      ST_RD_L: begin
        csx_d = 1'b0; rdx_d = 1'b0;
      end
`endif
      ST_RD_H: csx_d = 1'b0;
      default: ;
    endcase
  end

  // Control state and DBI strobes; reset forces the idle bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      csx_q   <= 1'b1;
      dcx_q   <= 1'b1;
      resx_q  <= 1'b1;
      wrx_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DBI_PHY_RD_EN
      rdx_q    <= 1'b1;
      rx_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      csx_q   <= csx_d;
      dcx_q   <= dcx_d;
      resx_q  <= resx_d;
      wrx_q   <= wrx_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
`ifdef DBI_PHY_RD_EN
      rdx_q    <= rdx_d;
      rx_vld_q <= rx_vld_d;
`endif
    end
  end

  // Payload and latched timing; meaningful only while a transaction is active.
  always_ff @(posedge clk) begin
    cmd_q    <= cmd_d;
    dat_q    <= dat_d;
    d_q      <= d_d;
    no_dat_q <= no_dat_d;
    last_q   <= last_d;
    rd_q     <= rd_d;
    wrl_q    <= wrl_d;
    wrh_q    <= wrh_d;
    hrst_q   <= hrst_d;
    pau_q    <= pau_d;
    rdl_q    <= rdl_d;
    rdh_q    <= rdh_d;
`ifdef DBI_PHY_RD_EN
    rx_dat_q <= rx_dat_d;
`endif
  end

  assign dbi_d_io   = oe_q ? d_q : {DBI_IF_D_W{1'bz}};
  assign dbi_csx_o  = csx_q;
  assign dbi_dcx_o  = dcx_q;
  assign dbi_resx_o = resx_q;
  assign dbi_wrx_o  = wrx_q;
  assign busy_o     = busy_q;
`ifdef DBI_PHY_RD_EN
  assign dbi_rdx_o    = rdx_q;
  assign dtf_rx_dat_o = rx_dat_q;
  assign dtf_rx_vld_o = rx_vld_q;
`else
  assign dbi_rdx_o = 1'b1;
`endif

endmodule

// File: tb/tb_dbi_phy_gen2.sv
// Directed bench for dbi_phy_gen2: strobe widths, write order, hw reset, async reset, optional read.
module tb_dbi_phy_gen2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cfg_wrl = 16'd1, cfg_wrh = 16'd1, cfg_hrst = 16'd1, cfg_pau = 16'd1;
  logic        hrst = 1'b0, no_dat = 1'b0, last = 1'b0, vld = 1'b0;
  logic [7:0]  cmd_typ = 8'h00, cmd_dat = 8'h00;
  logic        rdy, busy, csx, dcx, resx, rdx, wrx;
  wire  [7:0]  dbi_d;
`ifdef DBI_PHY_RD_EN
  logic        rd = 1'b0;
  logic [15:0] cfg_rdl = 16'd1, cfg_rdh = 16'd1;
  logic [7:0]  rx_dat;
  logic        rx_vld;
  assign dbi_d = (rdx === 1'b0) ? 8'h9C : 8'hzz;
`endif

  dbi_phy_gen2 dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_t_wrl_i      (cfg_wrl),
    .cfg_t_wrh_i      (cfg_wrh),
    .cfg_t_hrst_i     (cfg_hrst),
    .cfg_t_pau_i      (cfg_pau),
    .dtf_dbi_hrst_i   (hrst),
    .dtf_tx_cmd_typ_i (cmd_typ),
    .dtf_tx_cmd_dat_i (cmd_dat),
    .dtf_tx_no_dat_i  (no_dat),
    .dtf_tx_last_i    (last),
    .dtf_tx_vld_i     (vld),
    .dtf_tx_rdy_o     (rdy),
    .busy_o           (busy),
    .dbi_d_io         (dbi_d),
    .dbi_csx_o        (csx),
    .dbi_dcx_o        (dcx),
    .dbi_resx_o       (resx),
    .dbi_rdx_o        (rdx),
    .dbi_wrx_o        (wrx)
`ifdef DBI_PHY_RD_EN
    ,
    .dtf_rd_i         (rd),
    .cfg_t_rdl_i      (cfg_rdl),
    .cfg_t_rdh_i      (cfg_rdh),
    .dtf_rx_dat_o     (rx_dat),
    .dtf_rx_vld_o     (rx_vld)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int csx_low, wrx_low, resx_low, rdx_low, busy_cnt, csx_rise, n_wr, rx_cnt;
  logic [8:0] wr_log [8];
  logic [7:0] rx_last;
  logic       prev_csx, prev_wrx, prev_dcx;
  logic [7:0] prev_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    csx_low = 0; wrx_low = 0; resx_low = 0; rdx_low = 0;
    busy_cnt = 0; csx_rise = 0; n_wr = 0; rx_cnt = 0; rx_last = 8'h00;
    prev_csx = csx; prev_wrx = wrx; prev_dcx = dcx; prev_d = dbi_d;
  endtask

  // Advance one clock and record the bus as seen just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!csx)  csx_low++;
    if (!wrx)  wrx_low++;
    if (!resx) resx_low++;
    if (!rdx)  rdx_low++;
    if (busy)  busy_cnt++;
    if (csx && !prev_csx) csx_rise++;
    if (wrx && !prev_wrx) begin
      if (n_wr < 8) wr_log[n_wr] = {prev_dcx, prev_d};
      n_wr++;
    end
`ifdef DBI_PHY_RD_EN
    if (rx_vld) begin
      rx_cnt++;
      rx_last = rx_dat;
    end
`endif
    prev_csx = csx; prev_wrx = wrx; prev_dcx = dcx; prev_d = dbi_d;
  endtask

  task automatic send(input logic h, input logic [7:0] c, input logic [7:0] d,
                      input logic nd, input logic l);
    chk("rdy_before_beat", 32'(rdy), 32'd1);
    hrst = h; cmd_typ = c; cmd_dat = d; no_dat = nd; last = l; vld = 1'b1;
    tick();
    vld = 1'b0; hrst = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_rdy(input int max);
    int n = 0;
    while (!rdy && n < max) begin
      tick();
      n++;
    end
    chk("dat_wait_timeout", 32'(rdy), 32'd1);
  endtask

  initial begin
    logic [8:0] exp37 [4];
    exp37[0] = 9'h02C; exp37[1] = 9'h111; exp37[2] = 9'h122; exp37[3] = 9'h133;

    // Reset values while rst_n is held low.
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csx",  32'(csx),  32'd1);
    chk("rst_dcx",  32'(dcx),  32'd1);
    chk("rst_resx", 32'(resx), 32'd1);
    chk("rst_rdx",  32'(rdx),  32'd1);
    chk("rst_wrx",  32'(wrx),  32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_oe",   32'(dut.oe_q), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rdy_after_rst", 32'(rdy), 32'd1);

    // Command-only write 0x29.
    cfg_wrl = 16'd4; cfg_wrh = 16'd4; cfg_pau = 16'd3;
    clr();
    send(1'b0, 8'h29, 8'h00, 1'b1, 1'b1);
    wait_idle(100);
    chk("c29_csx_low",  32'(csx_low),  32'd8);
    chk("c29_wrx_low",  32'(wrx_low),  32'd4);
    chk("c29_n_wr",     32'(n_wr),     32'd1);
    chk("c29_wr0",      32'(wr_log[0]), 32'h029);
    chk("c29_busy",     32'(busy_cnt), 32'd11);
    chk("c29_csx_rise", 32'(csx_rise), 32'd1);

    // 0x2C with three data words and 10-cycle gaps between beats.
    cfg_wrl = 16'd2; cfg_wrh = 16'd3; cfg_pau = 16'd2;
    clr();
    send(1'b0, 8'h2C, 8'h11, 1'b0, 1'b0);
    wait_rdy(100);
    repeat (10) tick();
    chk("c2c_wait_csx", 32'(csx), 32'd0);
    send(1'b1, 8'h00, 8'h22, 1'b0, 1'b0);
    wait_rdy(100);
    repeat (10) tick();
    send(1'b0, 8'h00, 8'h33, 1'b0, 1'b1);
    wait_idle(100);
    chk("c2c_n_wr",     32'(n_wr),     32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("c2c_wr%0d", i), 32'(wr_log[i]), 32'(exp37[i]));
    chk("c2c_wrx_low",  32'(wrx_low),  32'd8);
    chk("c2c_csx_rise", 32'(csx_rise), 32'd1);
    chk("c2c_resx_low", 32'(resx_low), 32'd0);

    // Zero configs act as one cycle; mid-burst config changes are ignored.
    cfg_wrl = 16'd0; cfg_wrh = 16'd1; cfg_pau = 16'd0;
    clr();
    send(1'b0, 8'hB0, 8'h55, 1'b0, 1'b0);
    wait_rdy(100);
    cfg_wrl = 16'd7; cfg_wrh = 16'd7; cfg_pau = 16'd9;
    send(1'b0, 8'h00, 8'h66, 1'b0, 1'b1);
    wait_idle(100);
    chk("zero_wrx_low", 32'(wrx_low), 32'd3);
    chk("zero_n_wr",    32'(n_wr),    32'd3);
    chk("zero_wr2",     32'(wr_log[2]), 32'h166);
    chk("zero_busy",    32'(busy_cnt), 32'd8);

    // Hardware reset beat.
    cfg_hrst = 16'd1500; cfg_pau = 16'd5;
    clr();
    send(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_idle(3000);
    chk("hrst_resx_low", 32'(resx_low), 32'd1500);
    chk("hrst_busy",     32'(busy_cnt), 32'd1505);
    chk("hrst_csx_low",  32'(csx_low),  32'd0);
    chk("hrst_rdy",      32'(rdy),      32'd1);

    // Asynchronous reset in the middle of DAT_L.
    cfg_wrl = 16'd20; cfg_wrh = 16'd4; cfg_pau = 16'd2;
    clr();
    send(1'b0, 8'h3A, 8'h77, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!(dcx && !wrx) && n < 200) begin
        tick();
        n++;
      end
      chk("reach_dat_l", 32'(n < 200), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_csx",  32'(csx),  32'd1);
    chk("arst_dcx",  32'(dcx),  32'd1);
    chk("arst_wrx",  32'(wrx),  32'd1);
    chk("arst_resx", 32'(resx), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_oe",   32'(dut.oe_q), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("arst_rdy",       32'(rdy),  32'd1);
    chk("arst_busy_post", 32'(busy), 32'd0);

`ifdef DBI_PHY_RD_EN
    // Single-word read of 0x0A; the bench answers 0x9C while RDX is low.
    cfg_wrl = 16'd1; cfg_wrh = 16'd1; cfg_pau = 16'd1; cfg_rdl = 16'd3; cfg_rdh = 16'd2;
    clr();
    rd = 1'b1;
    send(1'b0, 8'h0A, 8'h00, 1'b0, 1'b1);
    rd = 1'b0;
    wait_idle(100);
    chk("rd_rdx_low", 32'(rdx_low), 32'd3);
    chk("rd_rx_cnt",  32'(rx_cnt),  32'd1);
    chk("rd_rx_dat",  32'(rx_last), 32'h9C);
    chk("rd_n_wr",    32'(n_wr),    32'd1);
    chk("rd_wr0",     32'(wr_log[0]), 32'h00A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
